// File: rtl/rv_instr_stim_gen.sv
// Pseudo-random RV32I instruction stream generator (ADDI/ADD/BEQ/JAL).
// A Galois LFSR drives a weighted type pick and the operand fields; words leave over valid/ready.
module rv_instr_stim_gen #(
  parameter int          DATA_WIDTH = 32,
  parameter int          DIR_WIDTH  = 5,
  parameter int          CNT_WIDTH  = 16,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_2025,
  parameter int unsigned W_ADDI     = 1,
  parameter int unsigned W_ADD      = 1,
  parameter int unsigned W_BEQ      = 1,
  parameter int unsigned W_JAL      = 1
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  num_instr,
  input  logic                  seed_load,
  input  logic [31:0]           seed,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic [1:0]            instr_type,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  cnt_addi,
  output logic [CNT_WIDTH-1:0]  cnt_add,
  output logic [CNT_WIDTH-1:0]  cnt_beq,
  output logic [CNT_WIDTH-1:0]  cnt_jal,
  output logic [1:0]            state_dbg
);

  localparam int unsigned W_TOT   = W_ADDI + W_ADD + W_BEQ + W_JAL;
  localparam logic [5:0]  W_TOT_V = 6'(W_TOT);
  localparam logic [5:0]  TH_ADDI = 6'(W_ADDI);
  localparam logic [5:0]  TH_ADD  = 6'(W_ADDI + W_ADD);
  localparam logic [5:0]  TH_BEQ  = 6'(W_ADDI + W_ADD + W_BEQ);

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  localparam logic [1:0] TYPE_ADDI = 2'd0;
  localparam logic [1:0] TYPE_ADD  = 2'd1;
  localparam logic [1:0] TYPE_BEQ  = 2'd2;
  localparam logic [1:0] TYPE_JAL  = 2'd3;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  generate
    if (DATA_WIDTH != 32) begin : g_bad_data_width
      $error("rv_instr_stim_gen: DATA_WIDTH must be 32");
    end
    if (DIR_WIDTH != 5) begin : g_bad_dir_width
      $error("rv_instr_stim_gen: DIR_WIDTH must be 5");
    end
    if (W_TOT == 0) begin : g_no_weights
      $error("rv_instr_stim_gen: at least one mix weight must be nonzero");
    end
    if (W_ADDI > 15 || W_ADD > 15 || W_BEQ > 15 || W_JAL > 15) begin : g_bad_weight
      $error("rv_instr_stim_gen: mix weights are 4-bit values");
    end
    if (LFSR_SEED == 32'd0) begin : g_zero_seed
      $error("rv_instr_stim_gen: LFSR_SEED must be nonzero");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state;
  logic [31:0]          lfsr;
  logic [31:0]          lfsr_next;
  logic [CNT_WIDTH-1:0] issued;
  logic [CNT_WIDTH-1:0] num_lat;
  logic                 xfer;

  // Handshake: a word transfers on any rising edge where instr_valid && instr_ready.
  // While valid is high and ready is low, instruction and instr_type hold steady,
  // because both are pure functions of the LFSR and the LFSR only moves on a transfer.
  assign xfer      = instr_valid && instr_ready;
  assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ LFSR_MASK) : (lfsr >> 1);
  assign state_dbg = state;

  logic [13:0] mix_prod;
  logic [5:0]  mix_r;
  logic [1:0]  sel_type;

  // Scale the low LFSR byte into [0, W_TOT) and walk the cumulative weights.
  assign mix_prod = {6'd0, lfsr[7:0]} * {8'd0, W_TOT_V};
  assign mix_r    = mix_prod[13:8];

  always_comb begin
    sel_type = TYPE_JAL;
    if (mix_r < TH_ADDI)     sel_type = TYPE_ADDI;
    else if (mix_r < TH_ADD) sel_type = TYPE_ADD;
    else if (mix_r < TH_BEQ) sel_type = TYPE_BEQ;
  end

  logic [DIR_WIDTH-1:0] rd;
  logic [DIR_WIDTH-1:0] rs1;
  logic [DIR_WIDTH-1:0] rs2;
  logic [12:0]          imm_b;
  logic [20:0]          imm_j;
  logic [31:0]          word;

  assign rd    = lfsr[8 +: DIR_WIDTH];
  assign rs1   = lfsr[13 +: DIR_WIDTH];
  assign rs2   = lfsr[18 +: DIR_WIDTH];
  assign imm_b = {lfsr[31:20], 1'b0};
  assign imm_j = {lfsr[31:12], 1'b0};

  always_comb begin
    word = 32'd0;
    case (sel_type)
      TYPE_ADDI: word = {lfsr[31:20], rs1, 3'b000, rd, OP_IMM};
      TYPE_ADD:  word = {7'b0000000, rs2, rs1, 3'b000, rd, OP_REG};
      TYPE_BEQ:  word = {imm_b[12], imm_b[10:5], rs2, rs1, 3'b000,
                         imm_b[4:1], imm_b[11], OP_BRANCH};
      default:   word = {imm_j[20], imm_j[10:1], imm_j[11], imm_j[19:12], rd, OP_JAL};
    endcase
  end

  assign instruction = word;
  assign instr_type  = sel_type;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state       <= S_IDLE;
      lfsr        <= LFSR_SEED;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      issued      <= '0;
      num_lat     <= '0;
      cnt_addi    <= '0;
      cnt_add     <= '0;
      cnt_beq     <= '0;
      cnt_jal     <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          // A seed load on the same edge as start seeds the run that start begins.
          if (seed_load) lfsr <= (seed == 32'd0) ? LFSR_SEED : seed;
          if (start) begin
            issued   <= '0;
            num_lat  <= num_instr;
            cnt_addi <= '0;
            cnt_add  <= '0;
            cnt_beq  <= '0;
            cnt_jal  <= '0;
            if (num_instr != '0) begin
              state       <= S_RUN;
              instr_valid <= 1'b1;
              busy        <= 1'b1;
              done        <= 1'b0;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (xfer) begin
            lfsr   <= lfsr_next;
            issued <= issued + CNT_WIDTH'(1);
            case (sel_type)
              TYPE_ADDI: cnt_addi <= sat_inc(cnt_addi);
              TYPE_ADD:  cnt_add  <= sat_inc(cnt_add);
              TYPE_BEQ:  cnt_beq  <= sat_inc(cnt_beq);
              default:   cnt_jal  <= sat_inc(cnt_jal);
            endcase
            if (issued == num_lat - CNT_WIDTH'(1)) begin
              state       <= S_DONE;
              instr_valid <= 1'b0;
              busy        <= 1'b0;
              done        <= 1'b1;
            end
          end
        end
        default: begin
          state       <= S_IDLE;
          instr_valid <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv_instr_stim_gen.sv
// Directed bench for rv_instr_stim_gen: a mixed-weight instance and a pure-ADD instance.
// Expected words come from hand-computed constants and an independent LFSR/encoder model.
module tb_rv_instr_stim_gen;

  localparam logic [31:0] RESET_SEED = 32'hACE1_2025;

  logic clk = 1'b0;
  logic arst = 1'b1;
  always #5 clk = ~clk;

  // mixed-weight instance
  logic        start_m = 0, seed_load_m = 0, ready_m = 0;
  logic [15:0] num_m = 0;
  logic [31:0] seed_m = 0;
  logic        valid_m, busy_m, done_m;
  logic [31:0] instr_m;
  logic [1:0]  type_m, state_m;
  logic [15:0] cnt_addi_m, cnt_add_m, cnt_beq_m, cnt_jal_m;

  // ADD-only instance
  logic        start_a = 0, seed_load_a = 0, ready_a = 0;
  logic [15:0] num_a = 0;
  logic [31:0] seed_a = 0;
  logic        valid_a, busy_a, done_a;
  logic [31:0] instr_a;
  logic [1:0]  type_a, state_a;
  logic [15:0] cnt_addi_a, cnt_add_a, cnt_beq_a, cnt_jal_a;

  rv_instr_stim_gen dut (
    .clk(clk), .arst(arst), .start(start_m), .num_instr(num_m),
    .seed_load(seed_load_m), .seed(seed_m), .instr_valid(valid_m),
    .instr_ready(ready_m), .instruction(instr_m), .instr_type(type_m),
    .busy(busy_m), .done(done_m), .cnt_addi(cnt_addi_m), .cnt_add(cnt_add_m),
    .cnt_beq(cnt_beq_m), .cnt_jal(cnt_jal_m), .state_dbg(state_m)
  );

  rv_instr_stim_gen #(.W_ADDI(0), .W_ADD(1), .W_BEQ(0), .W_JAL(0)) dut_add (
    .clk(clk), .arst(arst), .start(start_a), .num_instr(num_a),
    .seed_load(seed_load_a), .seed(seed_a), .instr_valid(valid_a),
    .instr_ready(ready_a), .instruction(instr_a), .instr_type(type_a),
    .busy(busy_a), .done(done_a), .cnt_addi(cnt_addi_a), .cnt_add(cnt_add_a),
    .cnt_beq(cnt_beq_a), .cnt_jal(cnt_jal_a), .state_dbg(state_a)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  logic [1:0]  exp_t_q[$];
  logic [31:0] obs_w[$];
  logic [1:0]  obs_t[$];

  function automatic logic [31:0] model_next(input logic [31:0] l);
    logic [31:0] s;
    s = {1'b0, l[31:1]};
    if (l[0]) s = s ^ 32'h8020_0003;
    return s;
  endfunction

  // with all four weights equal to 1, (L[7:0]*4)>>8 is simply L[7:6]
  function automatic logic [1:0] model_type(input logic [31:0] l);
    return l[7:6];
  endfunction

  function automatic logic [31:0] model_enc(input logic [31:0] l, input logic [1:0] t);
    logic [12:0] b;
    logic [20:0] j;
    b = {l[31:20], 1'b0};
    j = {l[31:12], 1'b0};
    case (t)
      2'd0:    return {l[31:20], l[17:13], 3'b000, l[12:8], 7'b0010011};
      2'd1:    return {7'd0, l[22:18], l[17:13], 3'b000, l[12:8], 7'b0110011};
      2'd2:    return {b[12], b[10:5], l[22:18], l[17:13], 3'b000, b[4:1], b[11], 7'b1100011};
      default: return {j[20], j[10:1], j[11], j[19:12], l[12:8], 7'b1101111};
    endcase
  endfunction

  task automatic build_exp(input logic [31:0] s, input int n);
    logic [31:0] l;
    l = s;
    exp_q.delete();
    exp_t_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_t_q.push_back(model_type(l));
      exp_q.push_back(model_enc(l, model_type(l)));
      l = model_next(l);
    end
  endtask

  task automatic do_reset();
    arst = 1'b1;
    repeat (3) @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
  endtask

  // leaves the bench on the first negedge after the start edge
  task automatic mix_start(input logic [31:0] s, input logic load, input logic [15:0] n);
    @(negedge clk);
    ready_m = 1'b0;
    seed_m = s;
    seed_load_m = load;
    num_m = n;
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    seed_load_m = 1'b0;
  endtask

  task automatic collect_mix(input int max_cycles, output logic timed_out);
    int cyc;
    cyc = 0;
    obs_w.delete();
    obs_t.delete();
    ready_m = 1'b1;
    while (!done_m && cyc < max_cycles) begin
      if (valid_m) begin
        obs_w.push_back(instr_m);
        obs_t.push_back(type_m);
      end
      @(negedge clk);
      cyc++;
    end
    timed_out = !done_m;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (valid_m !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid_m); end
    total++; if (busy_m !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_m); end
    total++; if (done_m !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done_m); end
    total++; if ({cnt_addi_m, cnt_add_m, cnt_beq_m, cnt_jal_m} !== 64'd0) begin
      bad++; $display("FAIL reset_cnts: got %h want 0", {cnt_addi_m, cnt_add_m, cnt_beq_m, cnt_jal_m});
    end
    total++; if (instr_m !== 32'hACE4_8013) begin bad++; $display("FAIL reset_word: got %h want ace48013", instr_m); end
    total++; if (type_m !== 2'd0) begin bad++; $display("FAIL reset_type: got %0d want 0", type_m); end
    total++; if (instr_a !== 32'h0184_8033) begin bad++; $display("FAIL reset_add_word: got %h want 01848033", instr_a); end
  endtask

  task automatic test_first_words();
    logic to;
    mix_start(32'd0, 1'b0, 16'd3);
    collect_mix(20, to);
    build_exp(RESET_SEED, 3);
    total++; if (to) begin bad++; $display("FAIL first_timeout: done not seen in budget"); end
    total++; if (obs_w.size() !== 3) begin bad++; $display("FAIL first_count: got %0d want 3", obs_w.size()); end
    if (obs_w.size() >= 3) begin
      total++; if (obs_w[0] !== 32'hACE4_8013) begin bad++; $display("FAIL first_w0: got %h want ace48013", obs_w[0]); end
      total++; if (obs_w[1] !== 32'hD652_0813) begin bad++; $display("FAIL first_w1: got %h want d6520813", obs_w[1]); end
      total++; if (obs_w[2] !== exp_q[2]) begin bad++; $display("FAIL first_w2: got %h want %h", obs_w[2], exp_q[2]); end
    end
    total++; if (32'(cnt_addi_m) + 32'(cnt_add_m) + 32'(cnt_beq_m) + 32'(cnt_jal_m) !== 32'd3) begin
      bad++; $display("FAIL first_cnt_sum: got %0d want 3", cnt_addi_m + cnt_add_m + cnt_beq_m + cnt_jal_m);
    end
    repeat (3) @(negedge clk);
    total++; if (done_m !== 1'b1 || valid_m !== 1'b0) begin
      bad++; $display("FAIL first_done_hold: got done=%b valid=%b want 1/0", done_m, valid_m);
    end
  endtask

  task automatic test_pure_add();
    int n_ok;
    ready_a = 1'b1;
    @(negedge clk);
    num_a = 16'd100;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    n_ok = 0;
    for (int i = 0; i < 100; i++) begin
      total++;
      if (valid_a !== 1'b1 || busy_a !== 1'b1 || instr_a[6:0] !== 7'b0110011 ||
          instr_a[14:12] !== 3'b000 || instr_a[31:25] !== 7'd0 || type_a !== 2'd1) begin
        bad++; $display("FAIL add_word[%0d]: got valid=%b word=%h type=%0d want 1/add/1", i, valid_a, instr_a, type_a);
      end
      @(negedge clk);
    end
    total++; if (done_a !== 1'b1 || valid_a !== 1'b0 || busy_a !== 1'b0) begin
      bad++; $display("FAIL add_done: got done=%b valid=%b busy=%b want 1/0/0", done_a, valid_a, busy_a);
    end
    total++; if (cnt_add_a !== 16'd100) begin bad++; $display("FAIL add_cnt: got %0d want 100", cnt_add_a); end
    total++; if ({cnt_addi_a, cnt_beq_a, cnt_jal_a} !== 48'd0) begin
      bad++; $display("FAIL add_others: got %h want 0", {cnt_addi_a, cnt_beq_a, cnt_jal_a});
    end
    repeat (3) @(negedge clk);
    total++; if (done_a !== 1'b1) begin bad++; $display("FAIL add_done_hold: got %b want 1", done_a); end
  endtask

  task automatic test_backpressure();
    logic [31:0] hold_w;
    logic [1:0]  hold_t;
    logic [31:0] hold_sum, sum;
    int xfers, stall, cyc;
    mix_start(32'h1234_5678, 1'b1, 16'd12);
    build_exp(32'h1234_5678, 12);
    obs_w.delete();
    xfers = 0; stall = 0; cyc = 0;
    hold_w = 0; hold_t = 0; hold_sum = 0;
    while (!done_m && cyc < 200) begin
      sum = 32'(cnt_addi_m) + 32'(cnt_add_m) + 32'(cnt_beq_m) + 32'(cnt_jal_m);
      if (xfers == 4 && stall < 5) begin
        ready_m = 1'b0;
        if (stall == 0) begin
          hold_w = instr_m; hold_t = type_m; hold_sum = sum;
        end else begin
          total++;
          if (instr_m !== hold_w || type_m !== hold_t || sum !== hold_sum || valid_m !== 1'b1) begin
            bad++; $display("FAIL bp_hold[%0d]: got %h/%0d/%0d want %h/%0d/%0d", stall, instr_m, type_m, sum, hold_w, hold_t, hold_sum);
          end
        end
        stall++;
      end else begin
        ready_m = 1'b1;
      end
      if (valid_m && ready_m) begin
        obs_w.push_back(instr_m);
        xfers++;
      end
      @(negedge clk);
      cyc++;
    end
    total++; if (!done_m) begin bad++; $display("FAIL bp_timeout: done not seen in budget"); end
    total++; if (obs_w.size() !== 12) begin bad++; $display("FAIL bp_count: got %0d want 12", obs_w.size()); end
    if (obs_w.size() > 4) begin
      total++; if (obs_w[4] !== hold_w) begin bad++; $display("FAIL bp_release: got %h want %h", obs_w[4], hold_w); end
    end
    for (int i = 0; i < obs_w.size() && i < 12; i++) begin
      total++; if (obs_w[i] !== exp_q[i]) begin bad++; $display("FAIL bp_seq[%0d]: got %h want %h", i, obs_w[i], exp_q[i]); end
    end
  endtask

  task automatic test_zero_count();
    do_reset();
    total++; if (done_m !== 1'b0) begin bad++; $display("FAIL zero_pre_done: got %b want 0", done_m); end
    mix_start(32'd0, 1'b0, 16'd0);
    total++; if (done_m !== 1'b1) begin bad++; $display("FAIL zero_done: got %b want 1", done_m); end
    for (int i = 0; i < 4; i++) begin
      total++; if (valid_m !== 1'b0 || busy_m !== 1'b0) begin
        bad++; $display("FAIL zero_quiet[%0d]: got valid=%b busy=%b want 0/0", i, valid_m, busy_m);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mix();
    logic to;
    int c[4];
    mix_start(32'h0000_0001, 1'b1, 16'd1000);
    collect_mix(1100, to);
    build_exp(32'h0000_0001, 1000);
    c = '{0, 0, 0, 0};
    foreach (exp_t_q[i]) c[exp_t_q[i]]++;
    total++; if (to) begin bad++; $display("FAIL mix_timeout: done not seen in budget"); end
    total++; if (obs_w.size() !== 1000) begin bad++; $display("FAIL mix_count: got %0d want 1000", obs_w.size()); end
    for (int i = 0; i < obs_w.size() && i < 1000; i++) begin
      total++; if (obs_w[i] !== exp_q[i] || obs_t[i] !== exp_t_q[i]) begin
        bad++; $display("FAIL mix_seq[%0d]: got %h/%0d want %h/%0d", i, obs_w[i], obs_t[i], exp_q[i], exp_t_q[i]);
      end
      if (obs_t[i] == 2'd2) begin
        total++; if (obs_w[i][6:0] !== 7'b1100011 || obs_w[i][14:12] !== 3'b000) begin
          bad++; $display("FAIL mix_beq[%0d]: got %h want beq opcode/funct3", i, obs_w[i]);
        end
      end
      if (obs_t[i] == 2'd3) begin
        total++; if (obs_w[i][6:0] !== 7'b1101111) begin
          bad++; $display("FAIL mix_jal[%0d]: got %h want jal opcode", i, obs_w[i]);
        end
      end
    end
    total++; if (32'(cnt_addi_m) + 32'(cnt_add_m) + 32'(cnt_beq_m) + 32'(cnt_jal_m) !== 32'd1000) begin
      bad++; $display("FAIL mix_sum: got %0d want 1000", 32'(cnt_addi_m) + 32'(cnt_add_m) + 32'(cnt_beq_m) + 32'(cnt_jal_m));
    end
    total++; if (cnt_addi_m !== 16'(c[0]) || cnt_add_m !== 16'(c[1]) || cnt_beq_m !== 16'(c[2]) || cnt_jal_m !== 16'(c[3])) begin
      bad++; $display("FAIL mix_cnts: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                      cnt_addi_m, cnt_add_m, cnt_beq_m, cnt_jal_m, c[0], c[1], c[2], c[3]);
    end
    total++; if (cnt_addi_m < 150 || cnt_addi_m > 350 || cnt_add_m < 150 || cnt_add_m > 350 ||
                 cnt_beq_m < 150 || cnt_beq_m > 350 || cnt_jal_m < 150 || cnt_jal_m > 350) begin
      bad++; $display("FAIL mix_range: got %0d/%0d/%0d/%0d want each 150..350", cnt_addi_m, cnt_add_m, cnt_beq_m, cnt_jal_m);
    end
  endtask

  task automatic test_seed_zero();
    logic to;
    mix_start(32'd0, 1'b1, 16'd5);
    collect_mix(20, to);
    build_exp(RESET_SEED, 5);
    total++; if (to || obs_w.size() !== 5) begin bad++; $display("FAIL seed0_count: got %0d want 5", obs_w.size()); end
    if (obs_w.size() > 0) begin
      total++; if (obs_w[0] !== 32'hACE4_8013) begin bad++; $display("FAIL seed0_w0: got %h want ace48013", obs_w[0]); end
    end
    for (int i = 0; i < obs_w.size() && i < 5; i++) begin
      total++; if (obs_w[i] !== exp_q[i]) begin bad++; $display("FAIL seed0_seq[%0d]: got %h want %h", i, obs_w[i], exp_q[i]); end
    end
  endtask

  task automatic test_ignore_in_run();
    int xfers, cyc;
    logic pulsed;
    mix_start(32'hCAFE_BABE, 1'b1, 16'd8);
    build_exp(32'hCAFE_BABE, 8);
    obs_w.delete();
    xfers = 0; cyc = 0; pulsed = 1'b0;
    ready_m = 1'b1;
    while (!done_m && cyc < 100) begin
      if (xfers == 2 && !pulsed) begin
        start_m = 1'b1; seed_load_m = 1'b1; seed_m = 32'h1111_1111; num_m = 16'd3;
        pulsed = 1'b1;
      end else begin
        start_m = 1'b0; seed_load_m = 1'b0;
      end
      if (valid_m) begin obs_w.push_back(instr_m); xfers++; end
      @(negedge clk);
      cyc++;
    end
    start_m = 1'b0; seed_load_m = 1'b0;
    total++; if (obs_w.size() !== 8) begin bad++; $display("FAIL ign_count: got %0d want 8", obs_w.size()); end
    for (int i = 0; i < obs_w.size() && i < 8; i++) begin
      total++; if (obs_w[i] !== exp_q[i]) begin bad++; $display("FAIL ign_seq[%0d]: got %h want %h", i, obs_w[i], exp_q[i]); end
    end
  endtask

  task automatic test_arst_midrun();
    mix_start(32'h0BAD_F00D, 1'b1, 16'd50);
    ready_m = 1'b1;
    repeat (10) @(negedge clk);
    total++; if (32'(cnt_addi_m) + 32'(cnt_add_m) + 32'(cnt_beq_m) + 32'(cnt_jal_m) !== 32'd10 || busy_m !== 1'b1) begin
      bad++; $display("FAIL arst_pre: got sum=%0d busy=%b want 10/1", 32'(cnt_addi_m) + 32'(cnt_add_m) + 32'(cnt_beq_m) + 32'(cnt_jal_m), busy_m);
    end
    #1 arst = 1'b1;
    #1;
    total++; if (valid_m !== 1'b0 || busy_m !== 1'b0 || done_m !== 1'b0 ||
                 {cnt_addi_m, cnt_add_m, cnt_beq_m, cnt_jal_m} !== 64'd0) begin
      bad++; $display("FAIL arst_immediate: got valid=%b busy=%b done=%b cnts=%h want all 0",
                      valid_m, busy_m, done_m, {cnt_addi_m, cnt_add_m, cnt_beq_m, cnt_jal_m});
    end
    repeat (3) @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    total++; if (valid_m !== 1'b0 || state_m !== 2'd0 || instr_m !== 32'hACE4_8013) begin
      bad++; $display("FAIL arst_after: got valid=%b state=%0d word=%h want 0/0/ace48013", valid_m, state_m, instr_m);
    end
  endtask

  initial begin
    test_reset();
    test_first_words();
    test_pure_add();
    test_backpressure();
    test_zero_count();
    test_mix();
    test_seed_zero();
    test_ignore_in_run();
    test_arst_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rv_instr_stim_gen.md
Name: rv_instr_stim_gen

Overview:
- Synthesizable, parametrised pseudo-random RV32I instruction stream generator for processor-level verification and on-FPGA self-test.
- Produces ADDI/ADD/BEQ/JAL instruction words from an LFSR, with a per-type weighted mix, programmable seed and programmable instruction count.
- Delivers words over a valid/ready handshake to the instruction-memory loader or core fetch port.
- Keeps per-type issue counters for end-of-run reporting.

Parameters:
- DATA_WIDTH, 32, instruction word width (fixed RV32 encoding; only 32 is legal).
- DIR_WIDTH, 5, register-address field width.
- CNT_WIDTH, 16, width of the count input and the per-type counters.
- LFSR_SEED, 32'hACE1_2025, LFSR reset value; must be nonzero.
- W_ADDI / W_ADD / W_BEQ / W_JAL, 1 each, 4-bit mix weights. A weight of 0 disables that type. All four zero is an elaboration error.

Ports:
- clk  in  1  clock
- arst  in  1  asynchronous active-high reset
- start  in  1  begin a run (sampled in IDLE or DONE only)
- num_instr  in  CNT_WIDTH  instructions to issue in the run
- seed_load  in  1  load seed into LFSR (IDLE/DONE only)
- seed  in  32  seed value; 0 is replaced by LFSR_SEED
- instr_valid  out  1  instruction word valid
- instr_ready  in  1  consumer accepts word
- instruction  out  DATA_WIDTH  instruction word
- instr_type  out  2  0=ADDI, 1=ADD, 2=BEQ, 3=JAL
- busy  out  1  run in progress
- done  out  1  run complete (held until next start)
- cnt_addi / cnt_add / cnt_beq / cnt_jal  out  CNT_WIDTH  accepted-instruction counts per type

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE; LFSR=LFSR_SEED.
  - instr_valid=0, busy=0, done=0, all counters=0, issued=0.
- FSM states IDLE, RUN, DONE:
  - IDLE/DONE, start=1, num_instr!=0: counters cleared, issued=0, done=0, go to RUN next cycle.
  - IDLE/DONE, start=1, num_instr=0: go to DONE with counters=0; done=1 next cycle.
  - RUN: instr_valid=1, busy=1. On transfer (valid&&ready):
    - LFSR advances one step.
    - Counter for instr_type increments.
    - issued increments.
    - If issued==num_instr-1 before the increment, go to DONE and drop valid next cycle.
  - num_instr is latched at start; later changes are ignored.
- LFSR: 32-bit Galois, mask 32'h8020_0003, shifts right. Advances only on transfer, so the sequence is independent of backpressure.
- Type select:
  - r = (L[7:0] * W_TOT) >> 8, where L is the current LFSR value and W_TOT is the sum of the weights.
  - Cumulative thresholds in ADDI, ADD, BEQ, JAL order; first type with r < cumulative weight wins.
- Encoding (combinational from the current LFSR value, so the word is stable while valid&&!ready):
  - Fields: rd=L[12:8], rs1=L[17:13], rs2=L[22:18], imm12=L[31:20].
  - ADDI: {imm12, rs1, 000, rd, 0010011}.
  - ADD: {0000000, rs2, rs1, 000, rd, 0110011}.
  - BEQ: imm13={L[31:20],0}, standard B-type scatter, funct3=000, opcode 1100011.
  - JAL: imm21={L[31:12],0}, standard J-type scatter, rd=L[12:8], opcode 1101111. Bits shared between rd and the immediate are permitted.
- Back-to-back: ready held high gives one instruction per cycle. The word after a transfer appears the following cycle with no bubble.
- Boundaries:
  - seed_load and start asserted together: seed load applies first, then the run starts with the new seed.
  - seed_load or start in RUN is ignored.
  - Counters saturate at all-ones.
  - arst mid-run aborts immediately; all outputs return to reset values.

Test Plan:
- Reset: assert arst for 3 cycles mid-run -> instr_valid=0, busy=0, done=0, all cnt_*=0 within the same cycle as assertion.
- Pure ADD (W_ADD=1, others 0), num_instr=100, ready=1 -> 100 transfers in 100 consecutive cycles. Every word has [6:0]=0110011, [14:12]=000, [31:25]=0. cnt_add=100, others 0. done=1 on cycle 101, held.
- Backpressure: ready=0 for 5 cycles during RUN -> instruction and instr_type constant; no counter change. Sequence after release matches a ready=1 reference run with the same seed.
- num_instr=0, start=1 -> busy stays 0, instr_valid never asserts, done=1 next cycle.
- Mix (all weights 1), seed=32'h1, num_instr=1000 -> cnt_addi+cnt_add+cnt_beq+cnt_jal=1000; each counter in 150..350. Every BEQ word has imm bit0=0 and funct3=000; every JAL word has opcode 1101111.
- seed_load with seed=0 then start -> sequence identical to a post-reset run (LFSR_SEED substituted).
